// File: rtl/acc_drain_ctrl.sv
// Drain sequencer for the accumulator bank: walks rows, requantizes each row
// and hands it downstream through a 2-entry output FIFO.
module acc_drain_ctrl #(
  parameter int DEPTH       = 8,
  parameter int ARRAY_M     = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5,
  parameter int IDX_WIDTH   = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [SHIFT_WIDTH-1:0]        shift,
  input  logic                          relu_en,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_WIDTH*ARRAY_M-1:0]  acc_idx_set,
  output logic [ARRAY_M-1:0]            acc_enable_set,
  output logic                          acc_drain,
  input  logic [ARRAY_M*DATA_WIDTH-1:0] acc_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ARRAY_M*OUT_WIDTH-1:0]  out_data,
  output logic [IDX_WIDTH-1:0]          out_row
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0]         LAST_ROW = IDX_WIDTH'(DEPTH - 1);
  localparam logic signed [DATA_WIDTH:0]   SAT_MAX  = (DATA_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [DATA_WIDTH:0]   SAT_MIN  = ~SAT_MAX;

  state_t                       state, state_nxt;
  logic [IDX_WIDTH-1:0]         row_q, row_nxt;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_nxt;
  logic                         relu_q, relu_nxt;
  logic                         issue, pop;

  logic [ARRAY_M*OUT_WIDTH-1:0] q_row_p0;
  logic                         head_vld_p1, tail_vld_p1;
  logic [ARRAY_M*OUT_WIDTH-1:0] head_data_p1, tail_data_p1;
  logic [IDX_WIDTH-1:0]         head_row_p1, tail_row_p1;

  // Rounding right shift (half up) with optional ReLU, kept one bit wider
  // than the accumulator so the rounding add cannot overflow.
  function automatic logic signed [DATA_WIDTH:0] requant(
    input logic signed [DATA_WIDTH-1:0] v,
    input logic [SHIFT_WIDTH-1:0]       s,
    input logic                         relu
  );
    logic signed [DATA_WIDTH:0] x, rnd, r;
    x = {v[DATA_WIDTH-1], v};
    if (s == '0) begin
      r = x;
    end else if (int'(s) >= DATA_WIDTH) begin
      r = x[DATA_WIDTH] ? '1 : '0;
    end else begin
      rnd = {{DATA_WIDTH{1'b0}}, 1'b1} << (s - 1'b1);
      r   = (x + rnd) >>> s;
    end
    if (relu && r[DATA_WIDTH]) r = '0;
    return r;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH:0] r);
    if (r > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
    if (r < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    return r[OUT_WIDTH-1:0];
  endfunction

  assign pop   = head_vld_p1 && out_ready;
  assign issue = (state == ISSUE) && (!tail_vld_p1 || pop);

  always_comb begin
    state_nxt = state;
    row_nxt   = row_q;
    shift_nxt = shift_q;
    relu_nxt  = relu_q;
    case (state)
      IDLE: if (start) begin
        shift_nxt = shift;
        relu_nxt  = relu_en;
        row_nxt   = '0;
        state_nxt = ISSUE;
      end
      ISSUE: if (issue) begin
        row_nxt = row_q + 1'b1;
        if (row_q == LAST_ROW) state_nxt = FLUSH;
      end
      // Leave as soon as the FIFO will be empty after this edge.
      FLUSH: if (!head_vld_p1 || (!tail_vld_p1 && pop)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_q   <= row_nxt;
      shift_q <= shift_nxt;
      relu_q  <= relu_nxt;
    end
  end

  assign busy           = (state == ISSUE) || (state == FLUSH);
  assign done           = (state == DONE);
  assign acc_drain      = issue;
  assign acc_enable_set = {ARRAY_M{issue}};
  assign acc_idx_set    = issue ? {ARRAY_M{row_q}} : '0;

  // Stage p0: requantize the row read in the issue cycle.
  always_comb begin
    q_row_p0 = '0;
    for (int m = 0; m < ARRAY_M; m++)
      q_row_p0[OUT_WIDTH*m +: OUT_WIDTH] =
        saturate(requant(acc_data[DATA_WIDTH*m +: DATA_WIDTH], shift_q, relu_q));
  end

  // Stage p1: 2-entry FIFO, head slot drives the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_vld_p1 <= 1'b0;
      tail_vld_p1 <= 1'b0;
    end else begin
      case ({issue, pop})
        2'b10: if (!head_vld_p1) head_vld_p1 <= 1'b1;
               else              tail_vld_p1 <= 1'b1;
        2'b01: begin
          head_vld_p1 <= tail_vld_p1;
          tail_vld_p1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case ({issue, pop})
      2'b10: if (!head_vld_p1) begin
        head_data_p1 <= q_row_p0;
        head_row_p1  <= row_q;
      end else begin
        tail_data_p1 <= q_row_p0;
        tail_row_p1  <= row_q;
      end
      2'b01: begin
        head_data_p1 <= tail_data_p1;
        head_row_p1  <= tail_row_p1;
      end
      2'b11: if (tail_vld_p1) begin
        head_data_p1 <= tail_data_p1;
        head_row_p1  <= tail_row_p1;
        tail_data_p1 <= q_row_p0;
        tail_row_p1  <= row_q;
      end else begin
        head_data_p1 <= q_row_p0;
        head_row_p1  <= row_q;
      end
      default: ;
    endcase
  end

  assign out_valid = head_vld_p1;
  assign out_data  = head_vld_p1 ? head_data_p1 : '0;
  assign out_row   = head_vld_p1 ? head_row_p1  : '0;

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Bench for acc_drain_ctrl: directed and randomized drain passes checked
// against a row-level requantization model with an expected-row queue.
module tb_acc_drain_ctrl;
  localparam int DEPTH = 8, ARRAY_M = 8, DATA_WIDTH = 32, OUT_WIDTH = 8;
  localparam int SHIFT_WIDTH = 5, IDX_WIDTH = 3;

  logic                          clk = 1'b0;
  logic                          reset, start, relu_en, out_ready;
  logic [SHIFT_WIDTH-1:0]        shift;
  logic                          busy, done, acc_drain, out_valid;
  logic [IDX_WIDTH*ARRAY_M-1:0]  acc_idx_set;
  logic [ARRAY_M-1:0]            acc_enable_set;
  logic [ARRAY_M*DATA_WIDTH-1:0] acc_data;
  logic [ARRAY_M*OUT_WIDTH-1:0]  out_data;
  logic [IDX_WIDTH-1:0]          out_row;

  acc_drain_ctrl #(.DEPTH(DEPTH), .ARRAY_M(ARRAY_M), .DATA_WIDTH(DATA_WIDTH),
                   .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .shift(shift), .relu_en(relu_en),
    .busy(busy), .done(done), .acc_idx_set(acc_idx_set), .acc_enable_set(acc_enable_set),
    .acc_drain(acc_drain), .acc_data(acc_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row));

  always #5 clk = ~clk;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH][ARRAY_M];

  always_comb begin
    acc_data = '0;
    for (int m = 0; m < ARRAY_M; m++)
      acc_data[DATA_WIDTH*m +: DATA_WIDTH] = mem[acc_idx_set[IDX_WIDTH-1:0]][m];
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: floor((v + 2^(s-1)) / 2^s), then ReLU, then clamp.
  function automatic logic signed [7:0] ref_q(input longint v, input int s, input bit relu);
    longint d, n, y;
    if (s == 0) y = v;
    else begin
      d = longint'(1) << s;
      n = v + d / 2;
      y = n / d;
      if ((n % d) != 0 && n < 0) y = y - 1;
    end
    if (relu && y < 0) y = 0;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  function automatic logic signed [7:0] el(input logic [63:0] d, input int m);
    return d[8*m +: 8];
  endfunction

  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return (cyc > 10);
      2: return (cyc % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  typedef struct { int row; logic [63:0] data; } row_t;
  row_t exp_q[$];

  task automatic build_expected(input int s, input bit relu);
    row_t e;
    exp_q.delete();
    for (int r = 0; r < DEPTH; r++) begin
      e.row  = r;
      e.data = '0;
      for (int m = 0; m < ARRAY_M; m++) e.data[8*m +: 8] = ref_q(longint'(mem[r][m]), s, relu);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_pass(input int mode, input int s, input bit relu, input bit spam,
                          input bit timing, output logic [63:0] row0);
    int cyc, done_cyc, n_done, hs, drains, drains_by10;
    logic prev_v, prev_r;
    logic [63:0] prev_d;
    logic [2:0] prev_row;
    row_t e;
    build_expected(s, relu);
    done_cyc = -1; n_done = 0; hs = 0; drains = 0; drains_by10 = 0;
    prev_v = 0; prev_r = 1; prev_d = '0; prev_row = '0; row0 = '0;
    @(posedge clk); #1;
    start = 1'b1; shift = 5'(s); relu_en = relu; out_ready = rdy(mode, 0);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (acc_drain) begin
        chk("issue_idx", acc_idx_set, {ARRAY_M{3'(drains)}});
        chk("issue_en", acc_enable_set, 8'hFF);
        drains++;
      end else begin
        chk("idle_if", {acc_idx_set, acc_enable_set}, '0);
      end
      if (cyc <= 10) drains_by10 = drains;
      if (timing && cyc <= 1) chk("busy_start", busy, (cyc == 1));
      if (prev_v && !prev_r) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_row", out_row, prev_row);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_row", out_row, 64'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("row_idx", out_row, e.row);
          chk("row_data", out_data, e.data);
        end
        if (timing) chk("hs_cycle", cyc, 2 + hs);
        if (out_row == 0) row0 = out_data;
        hs++;
      end
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        n_done++;
        chk("busy_at_done", busy, 0);
      end
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_row = out_row;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(posedge clk); #1;
      cyc++;
      start = spam && (done_cyc < 0);
      out_ready = rdy(mode, cyc);
    end
    start = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("done_count", n_done, 1);
    chk("rows_left", exp_q.size(), 0);
    chk("handshakes", hs, DEPTH);
    chk("drain_count", drains, DEPTH);
    chk("idle_valid", out_valid, 0);
    if (timing) chk("done_cycle", done_cyc, DEPTH + 2);
    if (mode == 1) chk("bp_drains", drains_by10, 2);
  endtask

  logic [63:0] r0;

  initial begin
    reset = 1'b0; start = 1'b0; shift = '0; relu_en = 1'b0; out_ready = 1'b1;
    for (int r = 0; r < DEPTH; r++) for (int m = 0; m < ARRAY_M; m++) mem[r][m] = 100*r + m;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drain", acc_drain, 0);
    chk("rst_if", {acc_idx_set, acc_enable_set}, '0);
    chk("rst_out", {out_valid, out_data, out_row}, '0);
    @(negedge clk); reset = 1'b1;

    // Basic timeline
    run_pass(0, 0, 0, 0, 1, r0);
    chk("basic_r0c7", el(r0, 7), 7);

    // Rounding
    for (int r = 0; r < DEPTH; r++) for (int m = 0; m < ARRAY_M; m++) mem[r][m] = r * m - 9;
    mem[0][0] = 5; mem[0][1] = 6; mem[0][2] = -5; mem[0][3] = -6;
    run_pass(0, 2, 0, 0, 0, r0);
    chk("rnd_5", el(r0, 0), 1);
    chk("rnd_6", el(r0, 1), 2);
    chk("rnd_m5", el(r0, 2), -1);
    chk("rnd_m6", el(r0, 3), -1);

    // ReLU and saturation
    mem[0][0] = -300; mem[0][1] = 300; mem[0][2] = -3; mem[0][3] = 40;
    run_pass(0, 0, 0, 0, 0, r0);
    chk("sat_m300", el(r0, 0), -128);
    chk("sat_300", el(r0, 1), 127);
    chk("sat_m3", el(r0, 2), -3);
    chk("sat_40", el(r0, 3), 40);
    run_pass(0, 0, 1, 0, 0, r0);
    chk("relu_m300", el(r0, 0), 0);
    chk("relu_300", el(r0, 1), 127);
    chk("relu_m3", el(r0, 2), 0);
    chk("relu_40", el(r0, 3), 40);

    // Backpressure, alternating ready, start spam
    run_pass(1, 1, 0, 0, 0, r0);
    run_pass(2, 3, 1, 0, 0, r0);
    run_pass(0, 0, 0, 1, 1, r0);

    // Reset in the middle of a pass
    @(posedge clk); #1; start = 1'b1;
    repeat (4) begin @(posedge clk); #1; start = 1'b0; end
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_drain", acc_drain, 0);
    chk("mid_rst_if", {acc_idx_set, acc_enable_set}, '0);
    chk("mid_rst_out", {out_valid, out_data, out_row}, '0);
    @(negedge clk); reset = 1'b1;
    repeat (3) begin @(negedge clk); chk("post_rst_quiet", {done, busy, out_valid}, '0); end
    run_pass(0, 0, 0, 0, 1, r0);

    // Randomized passes
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < DEPTH; r++)
        for (int m = 0; m < ARRAY_M; m++)
          mem[r][m] = (t % 2 == 0) ? $urandom : (int'($urandom_range(0, 4000)) - 2000);
      run_pass(3, (t % 2 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, r0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
